mem_dma_copy: RTL and testbench
===============================

// Module: mem_dma_copy
// PURPOSE
//  Bus-master block-copy engine for the 16-bit word memory; drives its read port
//  (rd_en/addr sampled posedge, data valid next cycle) and write port (written at negedge).
//  Copies len words src->dst at one word per cycle after a 1-cycle fill; used for boot
//  image relocation and screen/buffer moves without CPU involvement.
// PARAMETERS
//  ADDR_W  16  address width; all address/length arithmetic mod 2^ADDR_W
//  DATA_W  16  memory word width
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, synchronous, active-high
//  start        in   1       request copy; sampled only in IDLE
//  src_addr     in   ADDR_W  first source word address, captured with start
//  dst_addr     in   ADDR_W  first destination word address, captured with start
//  len          in   ADDR_W  word count, captured with start; 0 = no-op
//  busy         out  1       copy in progress
//  done         out  1       one-cycle pulse when the copy completes
//  mem_rd_en    out  1       memory read enable (registered)
//  mem_rd_addr  out  ADDR_W  memory read address (registered)
//  mem_rd_data  in   DATA_W  memory read data, valid the cycle after mem_rd_en
//  mem_wr_en    out  1       memory write enable (registered)
//  mem_wr_addr  out  ADDR_W  memory write address (registered)
//  mem_wr_data  out  DATA_W  = mem_rd_data, combinational pass-through
//  checksum     out  DATA_W  only with DMA_CHECKSUM_EN
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, mem_rd_en, mem_wr_en = 0; mem_rd_addr, mem_wr_addr,
//    internal counters = 0. Reset mid-copy aborts at once; words already written stay.
//  - States: IDLE -> RUN -> DRAIN -> IDLE (done pulse in the first IDLE cycle).
//  - IDLE, start=1, len!=0 (sampled edge E0): latch src/dst/len, go RUN. len=0: stay IDLE,
//    done=1 for the cycle after E0, no memory access, busy stays 0.
//  - Cycle k (k=1..len, RUN): mem_rd_en=1, mem_rd_addr=src+k-1. Cycle k (k=2..len+1):
//    mem_wr_en=1, mem_wr_addr=dst+k-2, mem_wr_data=mem_rd_data. Cycle len+1 is DRAIN
//    (write only). Cycle len+2: IDLE, done=1, busy=0. busy=1 for cycles 1..len+1.
//  - Total latency start->done = len+2 cycles; throughput 1 word/cycle.
//  - Address wrap: src+i and dst+i wrap mod 2^ADDR_W (0xFFFF+1 -> 0x0000).
//  - Overlap: result identical to sequential forward loop for i in 0..len-1:
//    M[dst+i]=M[src+i] (write of word i at negedge precedes read of word i+1 at posedge).
//    dst==src+1 replicates M[src]; dst<src behaves as memmove.
//  - start while busy or in done cycle: ignored, not queued. len=0xFFFF valid.
//  - Inputs src/dst/len may change after E0 without effect.
// CONFIGURATION
//  DMA_CHECKSUM_EN defined: checksum port present; cleared to 0 on start acceptance
//   (E0), adds each written word mod 2^DATA_W at the write cycle's posedge; final at done,
//   held until next accepted start; 0 after reset; len=0 gives 0.
//  Not defined: port and adder absent; all other behaviour identical.
// STRUCTURE
//  Shared package tiny16_mem_pkg: ADDR_W/DATA_W constants, dma_state_t enum
//   {IDLE, RUN, DRAIN}. Single module; no sub-module (FSM + two address counters +
//   remaining-count down-counter fit inline).
// TESTING
//  1 Basic: M[0x0100..0x0103]=1,2,3,4; src=0x0100,dst=0x0200,len=4 -> 0x0200..0x0203=1..4,
//    busy high 5 cycles, done pulse 6 cycles after start edge, src words unchanged.
//  2 len=0 start -> done on next cycle only, mem_rd_en/mem_wr_en never asserted.
//  3 Wrap: src=0xFFFE,dst=0x0010,len=3, M[FFFE,FFFF,0000]=A,B,C -> M[0x10..0x12]=A,B,C.
//  4 Overlap: M[0x10]=0xAAAA, src=0x10,dst=0x11,len=4 -> M[0x11..0x14]=0xAAAA;
//    then dst=0x0F,src=0x10 shifts down without corruption.
//  5 Reset at cycle 3 of len=8 copy -> next cycle all outputs 0, IDLE; only words 0,1
//    written; new start then completes normally. start during busy -> ignored.
//  6 DMA_CHECKSUM_EN: copy 1,2,3,0xFFFF -> checksum=0x0005 at done; held; cleared on start.

Source files
------------

// File: rtl/tiny16_mem_pkg.sv
// Shared constants and DMA state encoding for the tiny16 word memory.
package tiny16_mem_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } dma_state_t;

endpackage

// File: rtl/mem_dma_copy.sv
// Block-copy bus master for the tiny16 word memory: reads src, writes dst one word per cycle.
// Optional DMA_CHECKSUM_EN adds a running mod-2^DATA_W sum of written words on checksum_o.
module mem_dma_copy #(
    parameter int unsigned ADDR_W = tiny16_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = tiny16_mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [DATA_W-1:0] mem_wr_data_o
`ifdef DMA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum_o
`endif
);
    import tiny16_mem_pkg::*;

    dma_state_t        state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] remain_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic              busy_q;
    logic              done_q;
    logic              start_ok;

    // A start landing in the done cycle is dropped, not queued.
    assign start_ok = (state_q == IDLE) && start_i && !done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            remain_q  <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q   <= RUN;
                            busy_q    <= 1'b1;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= src_addr_i;
                            wr_addr_q <= dst_addr_i;
                            remain_q  <= len_i - ADDR_W'(1);
                        end
                    end
                end
                RUN: begin
                    // Writes trail reads by one cycle; the first write reuses the latched dst.
                    wr_en_q <= 1'b1;
                    if (wr_en_q) begin
                        wr_addr_q <= wr_addr_q + ADDR_W'(1);
                    end
                    if (remain_q == '0) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                        remain_q  <= remain_q - ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign mem_rd_en_o   = rd_en_q;
    assign mem_rd_addr_o = rd_addr_q;
    assign mem_wr_en_o   = wr_en_q;
    assign mem_wr_addr_o = wr_addr_q;
    assign mem_wr_data_o = mem_rd_data_i;

`ifdef DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (wr_en_q) begin
            csum_q <= csum_q + mem_rd_data_i;
        end
    end

    assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_mem_dma_copy.sv
// Self-checking bench for mem_dma_copy: memory model on the bus, forward-loop reference copy.
module tb_mem_dma_copy;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] src_addr_i, dst_addr_i, len_i;
    logic        busy_o, done_o, mem_rd_en_o, mem_wr_en_o;
    logic [15:0] mem_rd_addr_o, mem_wr_addr_o, mem_rd_data_i, mem_wr_data_o;
`ifdef DMA_CHECKSUM_EN
    logic [15:0] checksum_o;
`endif

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_dma_copy dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .src_addr_i   (src_addr_i),
        .dst_addr_i   (dst_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .mem_rd_en_o  (mem_rd_en_o),
        .mem_rd_addr_o(mem_rd_addr_o),
        .mem_rd_data_i(mem_rd_data_i),
        .mem_wr_en_o  (mem_wr_en_o),
        .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wr_data_o(mem_wr_data_o)
`ifdef DMA_CHECKSUM_EN
        ,
        .checksum_o   (checksum_o)
`endif
    );

    // Bus-side memory: read sampled at posedge, write lands at negedge.
    always @(posedge clk) if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o];
    always @(negedge clk) if (mem_wr_en_o) mem[mem_wr_addr_o] = mem_wr_data_o;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // Reference: plain sequential forward loop M[dst+i] = M[src+i].
    task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n,
                              output logic [15:0] sum);
        sum = '0;
        for (int i = 0; i < n; i++) begin
            logic [15:0] sa, da;
            sa = s + 16'(i);
            da = d + 16'(i);
            sum = sum + ref_mem[sa];
            ref_mem[da] = ref_mem[sa];
        end
    endtask

    function automatic int mem_diffs();
        int c = 0;
        for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) c++;
        return c;
    endfunction

    // Drives one copy and counts cycles whose bus/handshake outputs deviate from the
    // cycle-k timetable (reads at k=1..len, writes at k=2..len+1, done at len+2).
    task automatic copy_cycles(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                               input bit hold_start, output int errs, output int first_k);
        int n;
        n = int'(l);
        errs = 0;
        first_k = -1;
        src_addr_i = s;
        dst_addr_i = d;
        len_i      = l;
        start_i    = 1'b1;
        tick();
        start_i    = hold_start;
        src_addr_i = 16'($urandom);
        dst_addr_i = 16'($urandom);
        len_i      = 16'($urandom_range(0, 5));
        for (int k = 1; k <= n + 3; k++) begin
            bit ok, e_rd, e_wr;
            e_rd = (k <= n);
            e_wr = (k >= 2) && (k <= n + 1);
            ok = (mem_rd_en_o === e_rd) && (mem_wr_en_o === e_wr) &&
                 (busy_o === (k <= n + 1)) && (done_o === (k == n + 2));
            if (e_rd && mem_rd_addr_o !== s + 16'(k - 1)) ok = 1'b0;
            if (e_wr && (mem_wr_addr_o !== d + 16'(k - 2) || mem_wr_data_o !== mem_rd_data_i))
                ok = 1'b0;
            if (!ok) begin
                errs++;
                if (first_k < 0) first_k = k;
            end
            if (k == n + 2) start_i = 1'b0;
            if (k < n + 3) tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start_i = 1'b0;
        src_addr_i = '0;
        dst_addr_i = '0;
        len_i = '0;
        tick();
        tick();
        n_vec++;
        if ({busy_o, done_o, mem_rd_en_o, mem_wr_en_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, required 0000",
                     {busy_o, done_o, mem_rd_en_o, mem_wr_en_o});
        end
        n_vec++;
        if ({mem_rd_addr_o, mem_wr_addr_o} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_addr: got rd=%h wr=%h, required 0000/0000",
                     mem_rd_addr_o, mem_wr_addr_o);
        end
`ifdef DMA_CHECKSUM_EN
        n_vec++;
        if (checksum_o !== 16'h0) begin
            n_err++;
            $display("FAIL reset_checksum: got %h, required 0000", checksum_o);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        logic [15:0] sum;
        int errs, fk;
        for (int i = 0; i < 4; i++) poke(16'h0100 + 16'(i), 16'(i + 1));
        model_copy(16'h0100, 16'h0200, 4, sum);
        copy_cycles(16'h0100, 16'h0200, 16'd4, 1'b0, errs, fk);
        n_vec++;
        if (errs !== 0) begin
            n_err++;
            $display("FAIL basic_timing: got %0d bad cycles (first k=%0d), required 0", errs, fk);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mem[16'h0200 + 16'(i)] !== 16'(i + 1) || mem[16'h0100 + 16'(i)] !== 16'(i + 1)) begin
                n_err++;
                $display("FAIL basic_word%0d: got dst=%h src=%h, required %h", i,
                         mem[16'h0200 + 16'(i)], mem[16'h0100 + 16'(i)], 16'(i + 1));
            end
        end
`ifdef DMA_CHECKSUM_EN
        n_vec++;
        if (checksum_o !== sum) begin
            n_err++;
            $display("FAIL basic_checksum: got %h, required %h", checksum_o, sum);
        end
`endif
    endtask

    task automatic test_len_zero;
        src_addr_i = 16'h1234;
        dst_addr_i = 16'h4321;
        len_i = 16'h0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_vec++;
        if ({done_o, busy_o, mem_rd_en_o, mem_wr_en_o} !== 4'b1000) begin
            n_err++;
            $display("FAIL len0_done: got done/busy/rd/wr=%b, required 1000",
                     {done_o, busy_o, mem_rd_en_o, mem_wr_en_o});
        end
`ifdef DMA_CHECKSUM_EN
        n_vec++;
        if (checksum_o !== 16'h0) begin
            n_err++;
            $display("FAIL len0_checksum: got %h, required 0000", checksum_o);
        end
`endif
        tick();
        n_vec++;
        if ({done_o, busy_o, mem_rd_en_o, mem_wr_en_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL len0_after: got done/busy/rd/wr=%b, required 0000",
                     {done_o, busy_o, mem_rd_en_o, mem_wr_en_o});
        end
        n_vec++;
        if (mem_diffs() !== 0) begin
            n_err++;
            $display("FAIL len0_mem: got %0d changed words, required 0", mem_diffs());
        end
    endtask

    task automatic test_wrap;
        logic [15:0] v [3];
        logic [15:0] sum;
        int errs, fk;
        for (int i = 0; i < 3; i++) begin
            v[i] = 16'($urandom);
            poke(16'hFFFE + 16'(i), v[i]);
        end
        model_copy(16'hFFFE, 16'h0010, 3, sum);
        copy_cycles(16'hFFFE, 16'h0010, 16'd3, 1'b0, errs, fk);
        n_vec++;
        if (errs !== 0) begin
            n_err++;
            $display("FAIL wrap_timing: got %0d bad cycles (first k=%0d), required 0", errs, fk);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (mem[16'h0010 + 16'(i)] !== v[i]) begin
                n_err++;
                $display("FAIL wrap_word%0d: got %h, required %h", i, mem[16'h0010 + 16'(i)], v[i]);
            end
        end
    endtask

    task automatic test_overlap;
        logic [15:0] sum;
        int errs, fk;
        poke(16'h0010, 16'hAAAA);
        model_copy(16'h0010, 16'h0011, 4, sum);
        copy_cycles(16'h0010, 16'h0011, 16'd4, 1'b0, errs, fk);
        n_vec++;
        if (errs !== 0) begin
            n_err++;
            $display("FAIL overlap_up_timing: got %0d bad cycles (first k=%0d), required 0", errs, fk);
        end
        for (int i = 1; i <= 4; i++) begin
            n_vec++;
            if (mem[16'h0010 + 16'(i)] !== 16'hAAAA) begin
                n_err++;
                $display("FAIL overlap_rep%0d: got %h, required aaaa", i, mem[16'h0010 + 16'(i)]);
            end
        end
        for (int i = 0; i < 16; i++) poke(16'h0010 + 16'(i), 16'($urandom));
        model_copy(16'h0010, 16'h000F, 8, sum);
        copy_cycles(16'h0010, 16'h000F, 16'd8, 1'b0, errs, fk);
        n_vec++;
        if (errs !== 0 || mem_diffs() !== 0) begin
            n_err++;
            $display("FAIL overlap_down: got %0d bad cycles, %0d bad words, required 0/0",
                     errs, mem_diffs());
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] sum;
        int errs, fk;
        for (int i = 0; i < 8; i++) poke(16'h3000 + 16'(i), 16'($urandom));
        src_addr_i = 16'h3000;
        dst_addr_i = 16'h5000;
        len_i = 16'd8;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({busy_o, done_o, mem_rd_en_o, mem_wr_en_o, mem_rd_addr_o, mem_wr_addr_o} !== 36'h0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got busy/done/rd/wr=%b rd=%h wr=%h, required all 0",
                     {busy_o, done_o, mem_rd_en_o, mem_wr_en_o}, mem_rd_addr_o, mem_wr_addr_o);
        end
`ifdef DMA_CHECKSUM_EN
        n_vec++;
        if (checksum_o !== 16'h0) begin
            n_err++;
            $display("FAIL rstmid_checksum: got %h, required 0000", checksum_o);
        end
`endif
        model_copy(16'h3000, 16'h5000, 2, sum);
        n_vec++;
        if (mem_diffs() !== 0) begin
            n_err++;
            $display("FAIL rstmid_partial: got %0d bad words, required 0 (only words 0,1)",
                     mem_diffs());
        end
        model_copy(16'h3000, 16'h5100, 8, sum);
        copy_cycles(16'h3000, 16'h5100, 16'd8, 1'b0, errs, fk);
        n_vec++;
        if (errs !== 0 || mem_diffs() !== 0) begin
            n_err++;
            $display("FAIL rstmid_restart: got %0d bad cycles, %0d bad words, required 0/0",
                     errs, mem_diffs());
        end
    endtask

    task automatic test_start_ignored;
        logic [15:0] sum;
        int errs, fk;
        for (int i = 0; i < 5; i++) poke(16'h7000 + 16'(i), 16'($urandom));
        model_copy(16'h7000, 16'h7800, 5, sum);
        copy_cycles(16'h7000, 16'h7800, 16'd5, 1'b1, errs, fk);
        n_vec++;
        if (errs !== 0 || mem_diffs() !== 0) begin
            n_err++;
            $display("FAIL start_ignored: got %0d bad cycles (first k=%0d), %0d bad words, required 0/0",
                     errs, fk, mem_diffs());
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 8; t++) begin
            logic [15:0] s, d, l, sum;
            int errs, fk;
            s = 16'($urandom);
            l = 16'($urandom_range(1, 24));
            if (t % 3 == 0) d = s + 16'($urandom_range(0, 6)) - 16'd3;
            else d = 16'($urandom);
            model_copy(s, d, int'(l), sum);
            copy_cycles(s, d, l, 1'(t % 2), errs, fk);
            n_vec++;
            if (errs !== 0 || mem_diffs() !== 0) begin
                n_err++;
                $display("FAIL random%0d s=%h d=%h l=%0d: got %0d bad cycles, %0d bad words, required 0/0",
                         t, s, d, l, errs, mem_diffs());
            end
`ifdef DMA_CHECKSUM_EN
            n_vec++;
            if (checksum_o !== sum) begin
                n_err++;
                $display("FAIL random%0d_checksum: got %h, required %h", t, checksum_o, sum);
            end
`endif
        end
    endtask

`ifdef DMA_CHECKSUM_EN
    task automatic test_checksum;
        logic [15:0] sum;
        logic [15:0] vals [4];
        int errs, fk;
        vals = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFF};
        for (int i = 0; i < 4; i++) poke(16'h0400 + 16'(i), vals[i]);
        model_copy(16'h0400, 16'h0500, 4, sum);
        copy_cycles(16'h0400, 16'h0500, 16'd4, 1'b0, errs, fk);
        n_vec++;
        if (checksum_o !== 16'h0005 || errs !== 0) begin
            n_err++;
            $display("FAIL csum_final: got %h (%0d bad cycles), required 0005", checksum_o, errs);
        end
        tick();
        tick();
        n_vec++;
        if (checksum_o !== 16'h0005) begin
            n_err++;
            $display("FAIL csum_held: got %h, required 0005", checksum_o);
        end
        model_copy(16'h0400, 16'h0600, 2, sum);
        src_addr_i = 16'h0400;
        dst_addr_i = 16'h0600;
        len_i = 16'd2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_vec++;
        if (checksum_o !== 16'h0000) begin
            n_err++;
            $display("FAIL csum_clear: got %h, required 0000", checksum_o);
        end
        for (int k = 0; k < 4; k++) tick();
        n_vec++;
        if (checksum_o !== 16'h0003) begin
            n_err++;
            $display("FAIL csum_second: got %h, required 0003", checksum_o);
        end
    endtask
`endif

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a]     = 16'($urandom);
            ref_mem[a] = mem[a];
        end
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_overlap();
        test_reset_mid();
        test_start_ignored();
        test_random();
`ifdef DMA_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
